sprite_layer_engine: RTL and testbench

//  Multi-sprite successor to the single-piece sprite blocks. Draws up to NUM_SPRITES chess-piece sprites from one shared piece ROM.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_layer_engine_hit_unit.sv | 20 ++
 rtl/sprite_layer_engine.sv | 120 ++++++++++++
 tb/tb_sprite_layer_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite geometry, table entry type and ROM address width helper
package sprite_pkg;
  localparam int SPRITE_W        = 55;
  localparam int SPRITE_H        = 55;
  localparam int NUM_PIECES      = 12;
  localparam int PIECE_W         = $clog2(NUM_PIECES);
  localparam int TRANSPARENT_IDX = 0;
  typedef struct packed {
    logic               visible;
    logic [9:0]         x;
    logic [9:0]         y;
    logic [PIECE_W-1:0] piece;
  } sprite_entry_t;
  function automatic int rom_aw(input int pieces, input int w, input int h);
    return $clog2(pieces * w * h);
  endfunction
endpackage

// File: rtl/sprite_layer_engine_hit_unit.sv
// sprite_hit_unit: per-slot hit test; 11-bit subtraction so a borrow rejects pixels left/above the sprite
module sprite_hit_unit
  import sprite_pkg::*;
(
  input  sprite_entry_t entry_i,
  input  logic [9:0]    draw_x_i,
  input  logic [9:0]    draw_y_i,
  output logic          hit_o,
  output logic [9:0]    dx_o,
  output logic [9:0]    dy_o
);
  logic [10:0] dx;
  logic [10:0] dy;
  assign dx    = {1'b0, draw_x_i} - {1'b0, entry_i.x};
  assign dy    = {1'b0, draw_y_i} - {1'b0, entry_i.y};
  assign dx_o  = dx[9:0];
  assign dy_o  = dy[9:0];
  assign hit_o = entry_i.visible && !dx[10] && !dy[10] && dx[9:0] < 10'(SPRITE_W) &&
                 dy[9:0] < 10'(SPRITE_H) && 32'(entry_i.piece) < NUM_PIECES;
endmodule

// File: rtl/sprite_layer_engine.sv
// sprite_layer_engine: multi-sprite overlay with shadow/active tables and a 2-cycle ROM pipeline; SPRITE_HILITE_EN adds a blinking selection highlight
module sprite_layer_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 32,
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 16,
  localparam int SW          = $clog2(NUM_SPRITES),
  localparam int ROM_AW      = rom_aw(NUM_PIECES, SPRITE_W, SPRITE_H)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_idx,
  input  logic [9:0]         wr_x,
  input  logic [9:0]         wr_y,
  input  logic [PIECE_W-1:0] wr_piece,
  input  logic               wr_visible,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_index,
  output logic               pix_on
`ifdef SPRITE_HILITE_EN
  ,
  output logic               hilite_on,
  input  logic               sel_valid,
  input  logic [SW-1:0]      sel_idx
`endif
);
  sprite_entry_t shadow_q [NUM_SPRITES];
  sprite_entry_t active_q [NUM_SPRITES];
  sprite_entry_t wr_entry;
  logic [NUM_SPRITES-1:0] hit;
  logic [9:0] dx [NUM_SPRITES];
  logic [9:0] dy [NUM_SPRITES];
  logic any_hit;
  logic [SW-1:0] win;
  logic [ROM_AW-1:0] rom_addr_d, rom_addr_q;
  logic hit_q;
  logic on_d, pix_on_q;
  logic [IDX_W-1:0] pix_index_q;
  assign wr_entry = '{visible: wr_visible, x: wr_x, y: wr_y, piece: wr_piece};
  // Shadow table takes CPU-side writes at any time
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
    else if (wr_en) shadow_q[wr_idx] <= wr_entry;
  // Active table commits at frame start; a same-cycle write passes straight through
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= '0;
    else if (frame_start)
      for (int i = 0; i < NUM_SPRITES; i++)
        active_q[i] <= (wr_en && wr_idx == SW'(i)) ? wr_entry : shadow_q[i];
  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hit
    sprite_hit_unit u_hit (
      .entry_i  (active_q[s]),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .hit_o    (hit[s]),
      .dx_o     (dx[s]),
      .dy_o     (dy[s])
    );
  end
  // Highest hitting slot wins; only its pixel is fetched
  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      if (hit[i]) begin
        any_hit = 1'b1;
        win     = SW'(i);
      end
    rom_addr_d = any_hit ? ROM_AW'(32'(active_q[win].piece) * SPRITE_W * SPRITE_H +
                                   32'(dy[win]) * SPRITE_W + 32'(dx[win])) : '0;
  end
  // Stage 0: register the ROM address with its hit flag
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_q      <= any_hit;
    end
  assign rom_addr = rom_addr_q;
  assign on_d     = hit_q && rom_q != IDX_W'(TRANSPARENT_IDX);
  // Stage 2: register the palette index, zeroed whenever the pixel is see-through
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      pix_on_q    <= 1'b0;
      pix_index_q <= '0;
    end else begin
      pix_on_q    <= on_d;
      pix_index_q <= on_d ? rom_q : '0;
    end
  assign pix_on    = pix_on_q;
  assign pix_index = pix_index_q;
`ifdef SPRITE_HILITE_EN
  localparam int CW = $clog2(2 * BLINK_FRAMES);
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] win_q;
  logic hilite_q;
  // Blink phase counter, one step per frame, wrapping at two half-periods
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (frame_start) cnt_q <= (cnt_q == CW'(2 * BLINK_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
  // Winner slot travels with the hit flag, then qualifies the highlight
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      win_q    <= '0;
      hilite_q <= 1'b0;
    end else begin
      win_q    <= win;
      hilite_q <= on_d && sel_valid && win_q == sel_idx && cnt_q < CW'(BLINK_FRAMES);
    end
  assign hilite_on = hilite_q;
`endif
endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb_sprite_layer_engine: scoreboard bench with a geometric reference model of the sprite layer
module tb_sprite_layer_engine;
  localparam int NS = 32;
`ifdef SPRITE_HILITE_EN
  localparam int BF = 2;
`else
  localparam int BF = 16;
`endif
  logic vga_clk = 0, reset_n = 0, frame_start = 0, wr_en = 0, wr_visible = 0;
  logic [9:0] DrawX = 0, DrawY = 0, wr_x = 0, wr_y = 0;
  logic [4:0] wr_idx = 0;
  logic [3:0] wr_piece = 0;
  logic [15:0] rom_addr;
  logic [3:0] rom_q, pix_index;
  logic pix_on;
`ifdef SPRITE_HILITE_EN
  logic sel_valid = 0;
  logic [4:0] sel_idx = 0;
  logic hilite_on;
`endif

  always #5 vga_clk = ~vga_clk;

  sprite_layer_engine #(.NUM_SPRITES(NS), .IDX_W(4), .BLINK_FRAMES(BF)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_piece(wr_piece), .wr_visible(wr_visible),
    .rom_addr(rom_addr), .rom_q(rom_q), .pix_index(pix_index), .pix_on(pix_on)
`ifdef SPRITE_HILITE_EN
    , .hilite_on(hilite_on), .sel_valid(sel_valid), .sel_idx(sel_idx)
`endif
  );

  int rom_mode = 0;
  function automatic int rom_fn(input int a);
    if (rom_mode == 1) return 9;
    if (rom_mode == 2) return 0;
    return (a * 13 + (a >> 3)) % 16;
  endfunction
  always_comb rom_q = (rom_mode == 1) ? 4'd9 : (rom_mode == 2) ? 4'd0 :
                      4'((int'(rom_addr) * 13 + (int'(rom_addr) >> 3)) % 16);

  typedef struct {int addr; bit on; int idx; bit hil;} exp_t;
  int q_addr[$];
  exp_t q_pix[$];
  int vectors = 0, miscompares = 0;
  int s_vis[NS], s_x[NS], s_y[NS], s_p[NS];
  int a_vis[NS], a_x[NS], a_y[NS], a_p[NS];
  int cnt = 0;
  bit scan_v = 0;
  logic [1:0] vld;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_px(input int px, input int py, output int addr, output bit hit, output int win);
    hit = 0; addr = 0; win = 0;
    for (int s = NS - 1; s >= 0; s--)
      if (a_vis[s] != 0 && a_p[s] < 12 && px >= a_x[s] && px < a_x[s] + 55 &&
          py >= a_y[s] && py < a_y[s] + 55) begin
        hit = 1; win = s;
        addr = a_p[s] * 3025 + (py - a_y[s]) * 55 + (px - a_x[s]);
        break;
      end
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) vld <= 2'b00;
    else vld <= {vld[0], scan_v};

  always @(negedge vga_clk)
    if (reset_n) begin
      if (vld[0]) begin
        if (q_addr.size() == 0) check("addr_queue_underflow", 1, 0);
        else check("rom_addr", int'(rom_addr), q_addr.pop_front());
      end
      if (vld[1]) begin
        if (q_pix.size() == 0) check("pix_queue_underflow", 1, 0);
        else begin
          mon_e = q_pix.pop_front();
          check("pix_on", int'(pix_on), int'(mon_e.on));
          check("pix_index", int'(pix_index), mon_e.idx);
`ifdef SPRITE_HILITE_EN
          check("hilite_on", int'(hilite_on), int'(mon_e.hil));
`endif
        end
      end
    end

  task automatic drive(input bit we, input bit fs, input bit sv, input int px, input int py);
    int addr, win, w;
    bit hit;
    exp_t e;
    wr_en = we; frame_start = fs; scan_v = sv;
    DrawX = 10'(px); DrawY = 10'(py);
    e = '{0, 0, 0, 0};
    win = 0;
    if (sv) begin
      model_px(int'(DrawX), int'(DrawY), addr, hit, win);
      q_addr.push_back(addr);
      e.addr = addr;
      e.idx = rom_fn(addr);
      e.on = hit && e.idx != 0;
      if (!e.on) e.idx = 0;
    end
    if (we) begin
      w = int'(wr_idx);
      s_vis[w] = int'(wr_visible); s_x[w] = int'(wr_x); s_y[w] = int'(wr_y); s_p[w] = int'(wr_piece);
    end
    if (fs) begin
      a_vis = s_vis; a_x = s_x; a_y = s_y; a_p = s_p;
      cnt = (cnt + 1) % (2 * BF);
    end
    if (sv) begin
`ifdef SPRITE_HILITE_EN
      e.hil = e.on && sel_valid && win == int'(sel_idx) && cnt < BF;
`endif
      q_pix.push_back(e);
    end
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int p, input bit v);
    wr_idx = 5'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_piece = 4'(p); wr_visible = v;
  endtask
  task automatic write(input int idx, input int x, input int y, input int p, input bit v);
    set_wr(idx, x, y, p, v);
    drive(1, 0, 0, 0, 0);
  endtask
  task automatic frame(); drive(0, 1, 0, 0, 0); endtask
  task automatic scan(input int px, input int py); drive(0, 0, 1, px, py); endtask
  task automatic idle(input int n); repeat (n) drive(0, 0, 0, 0, 0); endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      s_vis[i] = 0; s_x[i] = 0; s_y[i] = 0; s_p[i] = 0;
      a_vis[i] = 0; a_x[i] = 0; a_y[i] = 0; a_p[i] = 0;
    end
    cnt = 0;
  endtask

  initial begin
    int s, px, py, r;
    model_clear();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_pix_on", int'(pix_on), 0);
    check("reset_pix_index", int'(pix_index), 0);
    reset_n = 1;
    @(posedge vga_clk); #1;
    // basic placement and first fetch
    write(0, 100, 50, 3, 1);
    frame();
    scan(100, 50); scan(101, 51); scan(99, 50);
    idle(2);
    // right/bottom edges with an opaque ROM
    rom_mode = 1;
    scan(154, 104); scan(155, 104); scan(154, 105); scan(100, 49);
    idle(2);
    // no wrap at the right screen edge; far-right sprite still hits
    rom_mode = 0;
    write(1, 1000, 0, 0, 1);
    write(3, 600, 300, 4, 1);
    frame();
    scan(5, 10); scan(1020, 10); scan(639, 310); scan(1023, 54);
    // overlap priority, then transparent winner
    write(2, 180, 180, 1, 1);
    write(7, 190, 190, 5, 1);
    frame();
    scan(200, 200); scan(185, 185); scan(240, 240);
    idle(2);
    rom_mode = 2;
    scan(200, 200); scan(185, 185);
    idle(2);
    rom_mode = 1;
    // shadow write is invisible until committed
    write(0, 300, 50, 3, 1);
    scan(100, 50); scan(300, 50);
    frame();
    scan(100, 50); scan(300, 50);
    // write-through on commit, and an out-of-range piece
    set_wr(4, 500, 400, 2, 1);
    drive(1, 1, 0, 0, 0);
    scan(510, 410);
    write(5, 700, 400, 13, 1);
    frame();
    scan(710, 410);
    idle(2);
`ifdef SPRITE_HILITE_EN
    sel_valid = 1; sel_idx = 5'd7;
    idle(2);
    for (int f = 0; f < 8; f++) begin
      frame();
      scan(200, 200); scan(182, 182);
    end
    idle(2);
    sel_valid = 0;
    idle(2);
`endif
    // randomized traffic over sprites scattered across the screen
    rom_mode = 0;
    for (int k = 0; k < NS; k++)
      write(k, $urandom_range(0, 1023), $urandom_range(0, 479), $urandom_range(0, 13), ($urandom % 4) != 0);
    frame();
    for (int k = 0; k < 400; k++) begin
      r = $urandom % 16;
      s = $urandom % NS;
      px = (a_x[s] + $urandom_range(0, 60) - 3) & 1023;
      py = (a_y[s] + $urandom_range(0, 60) - 3) & 1023;
      if (r <= 1) set_wr($urandom % NS, $urandom_range(0, 1023), $urandom_range(0, 479), $urandom_range(0, 13), ($urandom % 4) != 0);
      drive(r <= 1, r == 1 || r == 2, r != 3, px, py);
    end
    idle(2);
    // asynchronous reset mid-frame
    rom_mode = 1;
    write(6, 300, 300, 1, 1);
    frame();
    repeat (3) scan(310, 310);
    #2;
    check("pre_reset_pix_on", int'(pix_on), 1);
    reset_n = 0;
    #1;
    check("async_rst_rom_addr", int'(rom_addr), 0);
    check("async_rst_pix_on", int'(pix_on), 0);
    check("async_rst_pix_index", int'(pix_index), 0);
`ifdef SPRITE_HILITE_EN
    check("async_rst_hilite", int'(hilite_on), 0);
`endif
    scan_v = 0; wr_en = 0; frame_start = 0;
    q_addr.delete(); q_pix.delete();
    model_clear();
    #5;
    reset_n = 1;
    @(posedge vga_clk); #1;
    frame();
    scan(310, 310); scan(100, 50);
    idle(3);
    check("queues_drained", q_addr.size() + q_pix.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
